idli_sqi_arb_m: RTL and testbench
=================================

// Module: idli_sqi_arb_m
// PURPOSE
//  Arbitrates the single quad-SPI (SQI) memory port between instruction fetch
//  and the execution unit's immediate/data accesses. Sequences each transaction
//  nibble-serially (cmd, addr, dummy, data) so EX sees one nibble per cycle.
//  EX has priority. Fetch is preempted only on a 16b boundary. Sits between
//  fetch/EX and the SQI pads.
// PARAMETERS
//  DUMMY_CYCLES  2      read turnaround nibbles between addr and data (0..3)
//  RD_CMD        8'h03  command byte for reads
//  WR_CMD        8'h02  command byte for writes
// PORTS
//  i_arb_gck          in   1   clock
//  i_arb_rst          in   1   reset, asynchronous, active-high
//  i_arb_fe_req       in   1   fetch read request
//  i_arb_fe_addr      in   16  fetch start address
//  i_arb_fe_abort     in   1   fetch redirect: abandon fetch transaction
//  o_arb_fe_gnt       out  1   fetch owns the port
//  o_arb_fe_data_vld  out  1   o_arb_rd_data valid for fetch this cycle
//  i_arb_ex_req       in   1   EX request (held for the whole access)
//  i_arb_ex_wr        in   1   EX access is a write
//  i_arb_ex_addr      in   16  EX start address
//  i_arb_ex_wdata     in   4   EX write nibble (sqi_data_t)
//  o_arb_ex_gnt       out  1   EX owns the port
//  o_arb_ex_data_vld  out  1   EX read nibble valid / write nibble consumed
//  o_arb_rd_data      out  4   read nibble, shared by both requesters
//  i_arb_sqi_in       in   4   pad input nibble
//  o_arb_sqi_out      out  4   pad output nibble
//  o_arb_sqi_oe       out  1   pad output enable
//  o_arb_sqi_cs_n     out  1   chip select, active-low
// BEHAVIOUR
//  Reset (async, immediate): state IDLE, cs_n=1, oe=0, sqi_out=0, both gnt=0,
//   both data_vld=0, counters 0. Reset mid-transaction takes effect at once.
//  States: IDLE -> CMD (2) -> ADDR (4) -> [DUMMY (DUMMY_CYCLES), reads only]
//   -> DATA (unbounded) -> IDLE. DUMMY_CYCLES=0 goes ADDR->DATA directly.
//  IDLE: cs_n=1 for at least one cycle between transactions. Ex_req wins on a
//   tie. Winner's address and wr are latched at the grant edge. gnt is high from
//   the first CMD cycle through the last DATA cycle.
//  CMD: cs_n=0, oe=1, out = cmd[7:4] then cmd[3:0] (fetch and EX read use
//   RD_CMD; EX write uses WR_CMD).
//  ADDR: oe=1, out = addr[15:12], [11:8], [7:4], [3:0].
//  DUMMY: oe=0, out=0. No data_vld.
//  DATA read: oe=0, o_arb_rd_data = i_arb_sqi_in (combinational). The owner's
//   data_vld=1 every cycle.
//  DATA write: oe=1, out = i_arb_ex_wdata, o_arb_ex_data_vld=1 every cycle.
//  A 2b nibble counter runs in DATA and wraps 3->0. The 16b boundary is
//   counter==3.
//  End of transaction: next state is IDLE when the owner's req is low in the
//   cycle. That cycle's DATA nibble is not transferred (data_vld=0).
//  EX req dropped before DATA: transaction abandoned, next cycle IDLE.
//  Preemption: fetch in DATA while ex_req=1 makes the counter==3 cycle the last
//   fetch nibble, then IDLE, then EX is granted. Fetch is not preempted in
//   CMD/ADDR/DUMMY.
//  fe_abort while fetch owns the port, any state: next cycle IDLE, cs_n=1,
//   gnt=0. In that cycle data_vld=0. Abort with no fetch ownership is ignored.
//  fe_abort and fe_req together in IDLE: the request is granted with the new
//   address.
//  Outputs other than rd_data/data_vld are registered from state. Grant latency
//   is 1 cycle from req in IDLE.
// TESTING
//  1 Fetch read @0x1234, DUMMY=2: out 0,3,1,2,3,4; 2 dummy; data_vld from 9th
//    cycle after grant edge; cs_n=1 one cycle after req drop.
//  2 fe_req and ex_req (read @0x0010) same cycle in IDLE -> ex_gnt=1, fe_gnt=0
//    until EX ends + 1 IDLE cycle, then fetch granted.
//  3 EX write @0x00F0, data A,B,C,D -> out 0,2,0,0,F,0,A,B,C,D with oe=1; 4 ex
//    data_vld pulses; no dummy cycles.
//  4 ex_req rises at fetch DATA nibble 1 (counter=1) -> fetch gets nibbles 1..3,
//    cs_n=1 one cycle, then EX CMD starts.
//  5 fe_abort in 3rd ADDR cycle -> cs_n=1 and fe_gnt=0 next cycle; refetch
//    @0x0200 granted the cycle after.
//  6 i_arb_rst=1 mid EX write DATA -> cs_n=1, oe=0, gnt=0 without a clock edge;
//    idle after release.

Source files
------------

// File: rtl/idli_sqi_arb_m.sv
// SQI port arbiter: shares one quad-SPI memory between instruction fetch and EX,
// sequencing cmd/addr/dummy/data nibbles with EX priority and 16b-boundary preemption.
module idli_sqi_arb_m #(
   parameter int unsigned DUMMY_CYCLES = 2,
   parameter logic [7:0]  RD_CMD       = 8'h03,
   parameter logic [7:0]  WR_CMD       = 8'h02
) (
   input  logic        i_arb_gck,
   input  logic        i_arb_rst,
   input  logic        i_arb_fe_req,
   input  logic [15:0] i_arb_fe_addr,
   input  logic        i_arb_fe_abort,
   output logic        o_arb_fe_gnt,
   output logic        o_arb_fe_data_vld,
   input  logic        i_arb_ex_req,
   input  logic        i_arb_ex_wr,
   input  logic [15:0] i_arb_ex_addr,
   input  logic [3:0]  i_arb_ex_wdata,
   output logic        o_arb_ex_gnt,
   output logic        o_arb_ex_data_vld,
   output logic [3:0]  o_arb_rd_data,
   input  logic [3:0]  i_arb_sqi_in,
   output logic [3:0]  o_arb_sqi_out,
   output logic        o_arb_sqi_oe,
   output logic        o_arb_sqi_cs_n
);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DUMMY,
      ST_DATA
   } state_t;

   localparam logic [1:0] DUMMY_LAST = (DUMMY_CYCLES > 0) ? 2'(DUMMY_CYCLES - 1) : 2'd0;

   state_t      state, state_nxt;
   logic [1:0]  cnt, cnt_nxt;
   logic        owner_ex, owner_ex_nxt;
   logic        wr, wr_nxt;
   logic [15:0] addr, addr_nxt;
   logic        owner_req;
   logic        fe_kill;
   logic [7:0]  cmd_byte;

   always_ff @(posedge i_arb_gck or posedge i_arb_rst) begin
      if (i_arb_rst) begin
         state    <= ST_IDLE;
         cnt      <= 2'd0;
         owner_ex <= 1'b0;
         wr       <= 1'b0;
         addr     <= 16'd0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         owner_ex <= owner_ex_nxt;
         wr       <= wr_nxt;
         addr     <= addr_nxt;
      end
   end

   // cnt restarts at 0 on every state change; in DATA it is the nibble-in-halfword index
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = 2'd0;
      owner_ex_nxt = owner_ex;
      wr_nxt       = wr;
      addr_nxt     = addr;
      owner_req    = owner_ex ? i_arb_ex_req : i_arb_fe_req;
      fe_kill      = !owner_ex && i_arb_fe_abort;
      if (state == ST_IDLE) begin
         if (i_arb_ex_req) begin
            state_nxt    = ST_CMD;
            owner_ex_nxt = 1'b1;
            wr_nxt       = i_arb_ex_wr;
            addr_nxt     = i_arb_ex_addr;
         end else if (i_arb_fe_req) begin
            state_nxt    = ST_CMD;
            owner_ex_nxt = 1'b0;
            wr_nxt       = 1'b0;
            addr_nxt     = i_arb_fe_addr;
         end
      end else if (!owner_req || fe_kill) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_CMD: begin
               if (cnt == 2'd1) state_nxt = ST_ADDR;
               else cnt_nxt = cnt + 2'd1;
            end
            ST_ADDR: begin
               if (cnt == 2'd3) state_nxt = (wr || DUMMY_CYCLES == 0) ? ST_DATA : ST_DUMMY;
               else cnt_nxt = cnt + 2'd1;
            end
            ST_DUMMY: begin
               if (cnt == DUMMY_LAST) state_nxt = ST_DATA;
               else cnt_nxt = cnt + 2'd1;
            end
            ST_DATA: begin
               if (!owner_ex && i_arb_ex_req && cnt == 2'd3) state_nxt = ST_IDLE;
               else cnt_nxt = cnt + 2'd1;
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      cmd_byte          = wr ? WR_CMD : RD_CMD;
      o_arb_sqi_out     = 4'd0;
      o_arb_sqi_oe      = 1'b0;
      o_arb_fe_data_vld = 1'b0;
      o_arb_ex_data_vld = 1'b0;
      o_arb_rd_data     = 4'd0;
      case (state)
         ST_CMD: begin
            o_arb_sqi_oe  = 1'b1;
            o_arb_sqi_out = cnt[0] ? cmd_byte[3:0] : cmd_byte[7:4];
         end
         ST_ADDR: begin
            o_arb_sqi_oe = 1'b1;
            case (cnt)
               2'd0:    o_arb_sqi_out = addr[15:12];
               2'd1:    o_arb_sqi_out = addr[11:8];
               2'd2:    o_arb_sqi_out = addr[7:4];
               default: o_arb_sqi_out = addr[3:0];
            endcase
         end
         ST_DATA: begin
            if (wr) begin
               o_arb_sqi_oe      = 1'b1;
               o_arb_sqi_out     = i_arb_ex_wdata;
               o_arb_ex_data_vld = i_arb_ex_req;
            end else begin
               o_arb_rd_data = i_arb_sqi_in;
               if (owner_ex) o_arb_ex_data_vld = i_arb_ex_req;
               else          o_arb_fe_data_vld = i_arb_fe_req && !i_arb_fe_abort;
            end
         end
         default: ;
      endcase
   end

   assign o_arb_sqi_cs_n = (state == ST_IDLE);
   assign o_arb_fe_gnt   = (state != ST_IDLE) && !owner_ex;
   assign o_arb_ex_gnt   = (state != ST_IDLE) && owner_ex;

endmodule

// File: tb/tb_idli_sqi_arb_m.sv
// Bench for idli_sqi_arb_m: directed literal sequences plus randomized traffic
// compared every cycle against a transaction-offset model of the arbiter.
module tb_idli_sqi_arb_m;

   localparam int DUMMY = 2;

   logic        clk = 1'b0;
   logic        rst;
   logic        fe_req, fe_abort, fe_gnt, fe_vld;
   logic [15:0] fe_addr;
   logic        ex_req, ex_wr, ex_gnt, ex_vld;
   logic [15:0] ex_addr;
   logic [3:0]  ex_wdata, rd_data, sqi_in, sqi_out;
   logic        sqi_oe, cs_n;

   int n_vectors = 0;
   int n_miscompares = 0;

   // model: a transaction is just an owner, its latched request and a cycle offset since grant
   bit          m_busy = 0;
   bit          m_ex = 0;
   bit          m_wr = 0;
   logic [15:0] m_addr = 16'd0;
   int          m_pos = 0;

   logic [3:0] t1_hdr [6] = '{4'h0, 4'h3, 4'h1, 4'h2, 4'h3, 4'h4};
   logic [3:0] t1_rd  [3] = '{4'hA, 4'h5, 4'hC};
   logic [3:0] t2_hdr [6] = '{4'h0, 4'h3, 4'h0, 4'h0, 4'h1, 4'h0};
   logic [3:0] t3_hdr [6] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'hF, 4'h0};
   logic [3:0] t3_wd  [4] = '{4'hA, 4'hB, 4'hC, 4'hD};
   logic [3:0] t4_hdr [6] = '{4'h0, 4'h3, 4'h0, 4'h3, 4'h0, 4'h0};
   logic [3:0] t5_hdr [6] = '{4'h0, 4'h3, 4'h0, 4'h1, 4'h0, 4'h0};
   logic [3:0] t5_new [6] = '{4'h0, 4'h3, 4'h0, 4'h2, 4'h0, 4'h0};
   logic [3:0] t6_hdr [6] = '{4'h0, 4'h2, 4'h1, 4'h1, 4'h1, 4'h1};

   idli_sqi_arb_m #(.DUMMY_CYCLES(DUMMY), .RD_CMD(8'h03), .WR_CMD(8'h02)) dut (
      .i_arb_gck(clk), .i_arb_rst(rst),
      .i_arb_fe_req(fe_req), .i_arb_fe_addr(fe_addr), .i_arb_fe_abort(fe_abort),
      .o_arb_fe_gnt(fe_gnt), .o_arb_fe_data_vld(fe_vld),
      .i_arb_ex_req(ex_req), .i_arb_ex_wr(ex_wr), .i_arb_ex_addr(ex_addr),
      .i_arb_ex_wdata(ex_wdata), .o_arb_ex_gnt(ex_gnt), .o_arb_ex_data_vld(ex_vld),
      .o_arb_rd_data(rd_data), .i_arb_sqi_in(sqi_in), .o_arb_sqi_out(sqi_out),
      .o_arb_sqi_oe(sqi_oe), .o_arb_sqi_cs_n(cs_n)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vectors++;
      if (act !== exp) begin
         n_miscompares++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // one compare per cycle at the falling edge; model then advances to the next cycle
   always @(negedge clk) begin
      logic [23:0] hdr;
      logic        e_oe, e_fvld, e_xvld, owner_req, in_data;
      logic [3:0]  e_out;
      int          d, k;
      if (rst) begin
         m_busy = 0;
         check_output("rst_cs_n", {15'd0, cs_n}, 16'd1);
         check_output("rst_gnt", {14'd0, fe_gnt, ex_gnt}, 16'd0);
         check_output("rst_oe_out", {11'd0, sqi_oe, sqi_out}, 16'd0);
      end else begin
         e_oe = 0; e_out = 4'd0; e_fvld = 0; e_xvld = 0; in_data = 0; k = 0;
         if (m_busy) begin
            hdr = {(m_wr ? 8'h02 : 8'h03), m_addr};
            d   = m_wr ? 0 : DUMMY;
            if (m_pos < 6) begin
               e_oe  = 1;
               e_out = 4'((hdr >> (4 * (5 - m_pos))) & 24'hF);
            end else if (m_pos >= 6 + d) begin
               in_data = 1;
               k = (m_pos - 6 - d) % 4;
               if (m_wr) begin
                  e_oe = 1; e_out = ex_wdata; e_xvld = ex_req;
               end else if (m_ex) e_xvld = ex_req;
               else e_fvld = fe_req && !fe_abort;
            end
         end
         check_output("cs_n", {15'd0, cs_n}, {15'd0, !m_busy});
         check_output("fe_gnt", {15'd0, fe_gnt}, {15'd0, m_busy && !m_ex});
         check_output("ex_gnt", {15'd0, ex_gnt}, {15'd0, m_busy && m_ex});
         check_output("oe", {15'd0, sqi_oe}, {15'd0, e_oe});
         check_output("sqi_out", {12'd0, sqi_out}, {12'd0, e_out});
         check_output("fe_vld", {15'd0, fe_vld}, {15'd0, e_fvld});
         check_output("ex_vld", {15'd0, ex_vld}, {15'd0, e_xvld});
         if (e_fvld || (e_xvld && !m_wr)) check_output("rd_data", {12'd0, rd_data}, {12'd0, sqi_in});
         if (!m_busy) begin
            if (ex_req) begin
               m_busy = 1; m_ex = 1; m_wr = ex_wr; m_addr = ex_addr; m_pos = 0;
            end else if (fe_req) begin
               m_busy = 1; m_ex = 0; m_wr = 0; m_addr = fe_addr; m_pos = 0;
            end
         end else begin
            owner_req = m_ex ? ex_req : fe_req;
            if (!owner_req || (!m_ex && fe_abort)) m_busy = 0;
            else if (in_data && !m_ex && ex_req && k == 3) m_busy = 0;
            else m_pos++;
         end
      end
   end

   task automatic expect_cycle(input string name, input logic e_cs_n, input logic e_oe,
                               input logic [3:0] e_out, input logic e_fgnt, input logic e_xgnt,
                               input logic e_fvld, input logic e_xvld, input logic [3:0] e_rd);
      @(negedge clk);
      check_output({name, "_cs_n"}, {15'd0, cs_n}, {15'd0, e_cs_n});
      check_output({name, "_oe"}, {15'd0, sqi_oe}, {15'd0, e_oe});
      check_output({name, "_out"}, {12'd0, sqi_out}, {12'd0, e_out});
      check_output({name, "_gnt"}, {14'd0, fe_gnt, ex_gnt}, {14'd0, e_fgnt, e_xgnt});
      check_output({name, "_vld"}, {14'd0, fe_vld, ex_vld}, {14'd0, e_fvld, e_xvld});
      if (e_fvld || e_xvld) check_output({name, "_rd"}, {12'd0, rd_data}, {12'd0, e_rd});
      @(posedge clk);
      #1;
   endtask

   task automatic apply_stimulus();
      if (ex_req) ex_req = ($urandom_range(0, 11) != 0);
      else        ex_req = ($urandom_range(0, 9) == 0);
      if (fe_req) fe_req = ($urandom_range(0, 19) != 0);
      else        fe_req = ($urandom_range(0, 3) == 0);
      ex_wr    = 1'($urandom);
      ex_addr  = 16'($urandom);
      ex_wdata = 4'($urandom);
      fe_addr  = 16'($urandom);
      fe_abort = ($urandom_range(0, 29) == 0);
      sqi_in   = 4'($urandom);
      rst      = ($urandom_range(0, 599) == 0);
   endtask

   initial begin
      rst = 1; fe_req = 0; fe_addr = 0; fe_abort = 0; ex_req = 0; ex_wr = 0;
      ex_addr = 0; ex_wdata = 0; sqi_in = 0;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      expect_cycle("idle0", 1, 0, 0, 0, 0, 0, 0, 0);

      // fetch read @0x1234
      fe_req = 1; fe_addr = 16'h1234;
      expect_cycle("t1_req", 1, 0, 0, 0, 0, 0, 0, 0);
      fe_addr = 16'hFFFF;
      for (int i = 0; i < 6; i++) expect_cycle("t1_hdr", 0, 1, t1_hdr[i], 1, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) expect_cycle("t1_dummy", 0, 0, 0, 1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         sqi_in = t1_rd[i];
         expect_cycle("t1_data", 0, 0, 0, 1, 0, 1, 0, t1_rd[i]);
      end
      fe_req = 0;
      expect_cycle("t1_drop", 0, 0, 0, 1, 0, 0, 0, 0);
      expect_cycle("t1_idle", 1, 0, 0, 0, 0, 0, 0, 0);

      // simultaneous requests: EX read @0x0010 wins, fetch follows after one idle cycle
      fe_req = 1; fe_addr = 16'h0040; ex_req = 1; ex_wr = 0; ex_addr = 16'h0010;
      expect_cycle("t2_req", 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) expect_cycle("t2_hdr", 0, 1, t2_hdr[i], 0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) expect_cycle("t2_dummy", 0, 0, 0, 0, 1, 0, 0, 0);
      sqi_in = 4'h7;
      expect_cycle("t2_data", 0, 0, 0, 0, 1, 0, 1, 4'h7);
      sqi_in = 4'h8;
      expect_cycle("t2_data", 0, 0, 0, 0, 1, 0, 1, 4'h8);
      ex_req = 0;
      expect_cycle("t2_drop", 0, 0, 0, 0, 1, 0, 0, 0);
      expect_cycle("t2_gap", 1, 0, 0, 0, 0, 0, 0, 0);
      expect_cycle("t2_fe_cmd", 0, 1, 0, 1, 0, 0, 0, 0);
      fe_req = 0;
      expect_cycle("t2_fe_end", 0, 1, 4'h3, 1, 0, 0, 0, 0);
      expect_cycle("t2_idle", 1, 0, 0, 0, 0, 0, 0, 0);

      // EX write @0x00F0, data A..D
      ex_req = 1; ex_wr = 1; ex_addr = 16'h00F0;
      expect_cycle("t3_req", 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) expect_cycle("t3_hdr", 0, 1, t3_hdr[i], 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         ex_wdata = t3_wd[i];
         expect_cycle("t3_data", 0, 1, t3_wd[i], 0, 1, 0, 1, 0);
      end
      ex_req = 0; ex_wdata = 0;
      expect_cycle("t3_drop", 0, 1, 0, 0, 1, 0, 0, 0);
      expect_cycle("t3_idle", 1, 0, 0, 0, 0, 0, 0, 0);

      // preemption on the 16b boundary
      fe_req = 1; fe_addr = 16'h0300; ex_wr = 0; ex_addr = 16'h0020;
      expect_cycle("t4_req", 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) expect_cycle("t4_hdr", 0, 1, t4_hdr[i], 1, 0, 0, 0, 0);
      for (int i = 0; i < 2; i++) expect_cycle("t4_dummy", 0, 0, 0, 1, 0, 0, 0, 0);
      sqi_in = 4'h1;
      expect_cycle("t4_n0", 0, 0, 0, 1, 0, 1, 0, 4'h1);
      ex_req = 1;
      for (int i = 1; i < 4; i++) begin
         sqi_in = 4'(i + 1);
         expect_cycle("t4_n", 0, 0, 0, 1, 0, 1, 0, 4'(i + 1));
      end
      expect_cycle("t4_gap", 1, 0, 0, 0, 0, 0, 0, 0);
      expect_cycle("t4_ex_cmd", 0, 1, 0, 0, 1, 0, 0, 0);
      ex_req = 0; fe_req = 0;
      expect_cycle("t4_ex_end", 0, 1, 4'h3, 0, 1, 0, 0, 0);
      expect_cycle("t4_idle", 1, 0, 0, 0, 0, 0, 0, 0);

      // fetch abort in the third ADDR cycle, refetch @0x0200 with abort still high in IDLE
      fe_req = 1; fe_addr = 16'h0100;
      expect_cycle("t5_req", 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) expect_cycle("t5_hdr", 0, 1, t5_hdr[i], 1, 0, 0, 0, 0);
      fe_abort = 1;
      expect_cycle("t5_abort", 0, 1, t5_hdr[4], 1, 0, 0, 0, 0);
      fe_addr = 16'h0200;
      expect_cycle("t5_gap", 1, 0, 0, 0, 0, 0, 0, 0);
      fe_abort = 0;
      for (int i = 0; i < 6; i++) expect_cycle("t5_new", 0, 1, t5_new[i], 1, 0, 0, 0, 0);
      fe_abort = 1; fe_req = 0;
      expect_cycle("t5_end", 0, 0, 0, 1, 0, 0, 0, 0);
      fe_abort = 0;
      expect_cycle("t5_idle", 1, 0, 0, 0, 0, 0, 0, 0);

      // asynchronous reset in the middle of an EX write
      ex_req = 1; ex_wr = 1; ex_addr = 16'h1111; ex_wdata = 4'h5;
      expect_cycle("t6_req", 1, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 6; i++) expect_cycle("t6_hdr", 0, 1, t6_hdr[i], 0, 1, 0, 0, 0);
      for (int i = 0; i < 2; i++) expect_cycle("t6_data", 0, 1, 4'h5, 0, 1, 0, 1, 0);
      rst = 1;
      #1;
      check_output("t6_async_cs_n", {15'd0, cs_n}, 16'd1);
      check_output("t6_async_oe", {15'd0, sqi_oe}, 16'd0);
      check_output("t6_async_gnt", {14'd0, fe_gnt, ex_gnt}, 16'd0);
      check_output("t6_async_vld", {15'd0, ex_vld}, 16'd0);
      ex_req = 0;
      @(posedge clk);
      #1 rst = 0;
      expect_cycle("t6_idle", 1, 0, 0, 0, 0, 0, 0, 0);
      expect_cycle("t6_idle", 1, 0, 0, 0, 0, 0, 0, 0);

      $display("[TB] directed sequences done, starting random traffic");
      for (int c = 0; c < 5000; c++) begin
         apply_stimulus();
         @(posedge clk);
         #1;
      end
      rst = 0; fe_req = 0; ex_req = 0; fe_abort = 0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
      $finish;
   end

endmodule
